// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one Memory port between core (m0) and DMA (m1).
// Define MEM_ARB_STATS_EN to add grant/conflict counters.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int BURST_MAX    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]           m0_grant_cnt,
    output logic [31:0]           m1_grant_cnt,
    output logic [31:0]           conflict_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] mem_q
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t                state;
    logic [7:0]            burst_cnt;
    logic                  last_owner;
    logic                  full;
    logic                  accept;
    logic                  sel;
    logic [READ_LATENCY:0] pipe_v;
    logic [READ_LATENCY:0] pipe_id;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    always_comb begin
        full     = burst_cnt == 8'(BURST_MAX);
        m0_ready = m0_req && (state == OWN0 ? (!m1_req || !full) :
                              state == OWN1 ? (!m1_req || full) : (!m1_req || last_owner));
        m1_ready = m1_req && (state == OWN1 ? (!m0_req || !full) :
                              state == OWN0 ? (!m0_req || full) : (!m0_req || !last_owner));
        accept   = m0_ready || m1_ready;
        sel      = m1_ready;
    end
    // Read returns come straight from mem_q on the valid cycle; the hold regs keep rdata stable afterwards.
    assign m0_rvalid = pipe_v[READ_LATENCY] && !pipe_id[READ_LATENCY];
    assign m1_rvalid = pipe_v[READ_LATENCY] && pipe_id[READ_LATENCY];
    assign m0_rdata  = m0_rvalid ? mem_q : rdata0_q;
    assign m1_rdata  = m1_rvalid ? mem_q : rdata1_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_owner  <= 1'b1;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            pipe_v      <= '0;
            pipe_id     <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            if (accept) begin
                mem_address <= sel ? m1_addr : m0_addr;
                mem_data    <= sel ? m1_wdata : m0_wdata;
                last_owner  <= sel;
                state       <= sel ? OWN1 : OWN0;
                // Saturate so a long solo run still hands over as soon as the other master asks.
                burst_cnt   <= (state != IDLE && (state == OWN1) == sel) ?
                               (full ? burst_cnt : burst_cnt + 8'd1) : 8'd1;
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
            mem_wren <= accept && (sel ? m1_we : m0_we);
            pipe_v   <= {pipe_v[READ_LATENCY-1:0], accept && !(sel ? m1_we : m0_we)};
            pipe_id  <= {pipe_id[READ_LATENCY-1:0], sel};
            if (m0_rvalid) rdata0_q <= mem_q;
            if (m1_rvalid) rdata1_q <= mem_q;
        end
    end
`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            m0_grant_cnt <= '0;
            m1_grant_cnt <= '0;
            conflict_cnt <= '0;
        end else begin
            if (m0_ready) m0_grant_cnt <= m0_grant_cnt + 32'd1;
            if (m1_ready) m1_grant_cnt <= m1_grant_cnt + 32'd1;
            if (m0_req && m1_req) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with a 1-cycle-latency memory model.
module tb_mem_port_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [15:0] m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m0_ready, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_ready, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [15:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] m0_grant_cnt, m1_grant_cnt, conflict_cnt;
`endif
    logic [31:0] mem [0:65535];
    int          passed = 0;
    int          total = 0;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
`ifdef MEM_ARB_STATS_EN
        .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Memory: samples the registered address at the edge, q valid the following cycle.
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + 32'(i);
        tick; tick;
        reset = 1'b0;
        #1;
        chk("reset_wren", {31'd0, mem_wren}, 32'd0);
        chk("reset_addr", {16'd0, mem_address}, 32'd0);
        chk("reset_data", mem_data, 32'd0);
        chk("reset_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        chk("reset_rdata0", m0_rdata, 32'd0);
        chk("reset_rdata1", m1_rdata, 32'd0);
        chk("reset_ready", {30'd0, m0_ready, m1_ready}, 32'd0);

        // single read by m0
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        #1;
        chk("t1_ready", {30'd0, m0_ready, m1_ready}, 32'd2);
        tick;
        m0_req = 1'b0;
        #1;
        chk("t1_addr", {16'd0, mem_address}, 32'h10);
        chk("t1_wren", {31'd0, mem_wren}, 32'd0);
        chk("t1_early_rvalid", {31'd0, m0_rvalid}, 32'd0);
        tick;
        chk("t1_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
        chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        tick;
        chk("t1_rvalid_off", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        chk("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // both request continuously from reset: 8 x m0, 8 x m1, 8 x m0
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0101;
        #1;
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("t2_grant%0d", i), {30'd0, m0_ready, m1_ready},
                (i / 8) % 2 == 0 ? 32'd2 : 32'd1);
            tick;
            #1;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) tick;

        // m1 writes, m0 reads back the same address the next cycle
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0200; m1_wdata = 32'h12345678;
        #1;
        chk("t3_wready", {30'd0, m0_ready, m1_ready}, 32'd1);
        tick;
        m1_req = 1'b0; m1_we = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0200;
        #1;
        chk("t3_rready", {30'd0, m0_ready, m1_ready}, 32'd2);
        chk("t3_wren", {31'd0, mem_wren}, 32'd1);
        chk("t3_wdata", mem_data, 32'h12345678);
        chk("t3_waddr", {16'd0, mem_address}, 32'h200);
        tick;
        m0_req = 1'b0;
        #1;
        chk("t3_wren_off", {31'd0, mem_wren}, 32'd0);
        tick;
        chk("t3_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
        chk("t3_rdata", m0_rdata, 32'h12345678);
        repeat (2) tick;

        // four back-to-back reads by m0
        for (int i = 0; i < 7; i++) begin
            m0_req = i < 4;
            m0_addr = 16'(i);
            #1;
            if (i < 4) chk($sformatf("t4_ready%0d", i), {31'd0, m0_ready}, 32'd1);
            chk($sformatf("t4_rvalid%0d", i), {31'd0, m0_rvalid}, (i >= 2 && i < 6) ? 32'd1 : 32'd0);
            if (i >= 2 && i < 6) chk($sformatf("t4_rdata%0d", i), m0_rdata, 32'hA000_0000 + 32'(i - 2));
            tick;
        end
        m0_req = 1'b0;
        repeat (2) tick;

        // reset one cycle after a read accept cancels the pending return
        m0_req = 1'b1; m0_addr = 16'h0010;
        #1;
        chk("t5_ready", {31'd0, m0_ready}, 32'd1);
        tick;
        m0_req = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t5_rvalid_a", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        chk("t5_wren", {31'd0, mem_wren}, 32'd0);
        chk("t5_addr", {16'd0, mem_address}, 32'd0);
        chk("t5_data", mem_data, 32'd0);
        chk("t5_rdata0", m0_rdata, 32'd0);
        tick;
        chk("t5_rvalid_b", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        tick;
        chk("t5_rvalid_c", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);

`ifdef MEM_ARB_STATS_EN
        // 3 conflict cycles (all won by m0), 7 more m0 accepts, 5 m1 accepts
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h0300; m1_addr = 16'h0301;
        repeat (3) tick;
        m1_req = 1'b0;
        repeat (7) tick;
        m0_req = 1'b0; m1_req = 1'b1;
        repeat (5) tick;
        m1_req = 1'b0;
        tick;
        chk("t6_m0_cnt", m0_grant_cnt, 32'd10);
        chk("t6_m1_cnt", m1_grant_cnt, 32'd5);
        chk("t6_conflict", conflict_cnt, 32'd3);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_m0_rst", m0_grant_cnt, 32'd0);
        chk("t6_m1_rst", m1_grant_cnt, 32'd0);
        chk("t6_conf_rst", conflict_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
